// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch stage: PC, req/gnt/rvalid memory read, instruction
// register with decoded fields and a sticky fault vector.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic        pc_wr,
   input  logic [31:0] pc_wdata,
   input  logic        pc_inc,
   input  logic        fault_clr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic        ir_valid,
   output logic        fetch_busy,
   output logic [7:0]  fault_vector
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [3:0] {
      IDLE = 4'b0001,
      REQ  = 4'b0010,
      WAIT = 4'b0100,
      DONE = 4'b1000
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   instr_q, instr_d;
   logic          irv_q, irv_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    fault_q, fault_d;
   logic [3:0]    fault_set;
   logic          capture;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         instr_q <= NOP;
         irv_q   <= 1'b0;
         cnt_q   <= '0;
         fault_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         irv_q   <= irv_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      addr_d    = addr_q;
      instr_d   = instr_q;
      irv_d     = irv_q;
      cnt_d     = cnt_q;
      fault_set = '0;
      capture   = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (pc_wr) begin
               pc_d  = pc_wdata;
               irv_d = 1'b0;
            end else if (pc_inc) begin
               pc_d  = pc_q + 32'd4;
               irv_d = 1'b0;
            end
            state_d = IDLE;
            // The fetch address and alignment check use the PC as it was this cycle.
            if (fetch_req) begin
               if (pc_q[1:0] == 2'b00) begin
                  state_d = REQ;
                  irv_d   = 1'b0;
                  cnt_d   = '0;
                  addr_d  = pc_q;
               end else begin
                  fault_set[0] = 1'b1;
               end
            end
         end
         REQ, WAIT: begin
            if (pc_wr || pc_inc) fault_set[3] = 1'b1;
            capture = imem_rvalid && ((state_q == WAIT) || imem_gnt);
            if (capture) begin
               instr_d = imem_rdata;
               irv_d   = 1'b1;
               state_d = DONE;
               if (imem_rdata[1:0] != 2'b11) fault_set[2] = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               fault_set[1] = 1'b1;
               irv_d        = 1'b0;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if ((state_q == REQ) && imem_gnt) state_d = WAIT;
            end
         end
         default: state_d = IDLE;
      endcase
      fault_d = (fault_clr ? 4'b0000 : fault_q) | fault_set;
   end

   assign imem_req     = (state_q == REQ);
   assign imem_addr    = addr_q;
   assign fetch_busy   = (state_q == REQ) || (state_q == WAIT);
   assign pc           = pc_q;
   assign instr        = instr_q;
   assign ir_valid     = irv_q;
   assign fault_vector = {4'b0000, fault_q};
   assign opcode       = instr_q[6:0];
   assign rd           = instr_q[11:7];
   assign funct3       = instr_q[14:12];
   assign rs1          = instr_q[19:15];
   assign rs2          = instr_q[24:20];
   assign funct7       = instr_q[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: inputs change 1 time unit after the rising
// edge and outputs are checked there, so each tick is one fetch cycle.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_req = 1'b0, pc_wr = 1'b0, pc_inc = 1'b0, fault_clr = 1'b0;
   logic [31:0] pc_wdata = '0;
   logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        imem_req, ir_valid, fetch_busy;
   logic [31:0] imem_addr, pc, instr;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd, rs1, rs2;
   logic [7:0]  fault_vector;

   int checks = 0;
   int errors = 0;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_wr(pc_wr), .pc_wdata(pc_wdata),
      .pc_inc(pc_inc), .fault_clr(fault_clr), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc(pc),
      .instr(instr), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
      .rs1(rs1), .rs2(rs2), .ir_valid(ir_valid), .fetch_busy(fetch_busy),
      .fault_vector(fault_vector)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_pc"}, pc, 32'h0);
      chk({tag, "_instr"}, instr, 32'h0000_0013);
      chk({tag, "_irv"}, ir_valid, 0);
      chk({tag, "_req"}, imem_req, 0);
      chk({tag, "_busy"}, fetch_busy, 0);
      chk({tag, "_fault"}, fault_vector, 8'h00);
   endtask

   int req_cnt;
   int busy_cnt;

   initial begin
      // reset state
      tick();
      chk_reset_outputs("rst");
      rst = 1'b0;
      tick();

      // zero-wait fetch
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      chk("t1_req", imem_req, 1);
      chk("t1_addr", imem_addr, 32'h0);
      chk("t1_irv_c1", ir_valid, 0);
      imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0080_00B3;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b0;
      chk("t1_irv_c2", ir_valid, 1);
      chk("t1_instr", instr, 32'h0080_00B3);
      chk("t1_opcode", opcode, 7'h33);
      chk("t1_rd", rd, 5'd1);
      chk("t1_rs1", rs1, 5'd0);
      chk("t1_rs2", rs2, 5'd8);
      chk("t1_funct3", funct3, 3'd0);
      chk("t1_funct7", funct7, 7'd0);
      chk("t1_fault", fault_vector, 8'h00);
      tick();
      chk("t1_idle_irv", ir_valid, 1);
      chk("t1_idle_busy", fetch_busy, 0);

      // gnt 3 cycles late, rvalid 2 cycles after gnt
      pc_inc = 1'b1;
      tick();
      pc_inc = 1'b0;
      chk("t2_pc", pc, 32'h4);
      chk("t2_inc_irv", ir_valid, 0);
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      req_cnt = 0;
      for (int c = 1; c <= 6; c++) begin
         imem_gnt    = (c == 4);
         imem_rvalid = (c == 6);
         imem_rdata  = (c == 6) ? 32'h00A0_0093 : 32'hDEAD_BEEF;
         if (imem_req) begin
            req_cnt++;
            chk("t2_addr", imem_addr, 32'h4);
         end
         chk("t2_irv_wait", ir_valid, 0);
         tick();
      end
      imem_gnt = 1'b0; imem_rvalid = 1'b0;
      chk("t2_req_cycles", req_cnt, 4);
      chk("t2_irv_c7", ir_valid, 1);
      chk("t2_instr", instr, 32'h00A0_0093);
      chk("t2_fault", fault_vector, 8'h00);

      // timeout with no grant
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      busy_cnt = 0;
      for (int c = 0; c < 40 && fetch_busy; c++) begin
         busy_cnt++;
         tick();
      end
      chk("t3_busy_cycles", busy_cnt, 16);
      chk("t3_fault", fault_vector, 8'h02);
      chk("t3_irv", ir_valid, 0);
      chk("t3_req", imem_req, 0);
      imem_rvalid = 1'b1; imem_rdata = 32'h1234_5677;
      tick();
      imem_rvalid = 1'b0;
      chk("t3_late_instr", instr, 32'h00A0_0093);
      chk("t3_late_irv", ir_valid, 0);

      // misaligned PC, then aligned fetch
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      chk("t4_clr", fault_vector, 8'h00);
      pc_wr = 1'b1; pc_wdata = 32'h0000_0102;
      tick();
      pc_wr = 1'b0;
      chk("t4_pc102", pc, 32'h102);
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      chk("t4_mis_req", imem_req, 0);
      chk("t4_mis_busy", fetch_busy, 0);
      chk("t4_mis_fault", fault_vector, 8'h01);
      fault_clr = 1'b1; pc_wr = 1'b1; pc_wdata = 32'h0000_0100;
      tick();
      fault_clr = 1'b0; pc_wr = 1'b0;
      chk("t4_clr2", fault_vector, 8'h00);
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      chk("t4_req", imem_req, 1);
      chk("t4_addr", imem_addr, 32'h100);

      // PC update while busy, clear-vs-set, zero rdata
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      chk("t5_wait_req", imem_req, 0);
      chk("t5_wait_busy", fetch_busy, 1);
      pc_inc = 1'b1;
      tick();
      pc_inc = 1'b0;
      chk("t5_busy_pc", pc, 32'h100);
      chk("t5_busy_fault", fault_vector, 8'h08);
      fault_clr = 1'b1; pc_wr = 1'b1; pc_wdata = 32'h0000_0500;
      tick();
      fault_clr = 1'b0; pc_wr = 1'b0;
      chk("t5_setwins", fault_vector, 8'h08);
      chk("t5_busy_pc2", pc, 32'h100);
      imem_rvalid = 1'b1; imem_rdata = 32'h0000_0000;
      tick();
      imem_rvalid = 1'b0;
      chk("t5_zero_instr", instr, 32'h0);
      chk("t5_zero_irv", ir_valid, 1);
      chk("t5_zero_fault", fault_vector, 8'h0C);

      // PC wrap and pc_wr priority
      fault_clr = 1'b1; pc_wr = 1'b1; pc_wdata = 32'hFFFF_FFFC;
      tick();
      fault_clr = 1'b0; pc_wr = 1'b0;
      chk("t6_pcmax", pc, 32'hFFFF_FFFC);
      chk("t6_upd_irv", ir_valid, 0);
      pc_inc = 1'b1;
      tick();
      pc_inc = 1'b0;
      chk("t6_wrap", pc, 32'h0);
      pc_wr = 1'b1; pc_inc = 1'b1; pc_wdata = 32'h0000_0200;
      tick();
      pc_wr = 1'b0; pc_inc = 1'b0;
      chk("t6_prio", pc, 32'h200);
      chk("t6_fault", fault_vector, 8'h00);

      // fetch_req together with pc_wr: fetch uses old pc
      fetch_req = 1'b1; pc_wr = 1'b1; pc_wdata = 32'h0000_0300;
      tick();
      fetch_req = 1'b0; pc_wr = 1'b0;
      chk("t7_pc", pc, 32'h300);
      chk("t7_req", imem_req, 1);
      chk("t7_addr", imem_addr, 32'h200);
      imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0093;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b0;
      chk("t7_irv", ir_valid, 1);
      tick();

      // async reset during WAIT
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      chk("t8_addr", imem_addr, 32'h300);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      chk("t8_wait", fetch_busy, 1);
      #1 rst = 1'b1;
      #1 chk_reset_outputs("t8_async");
      tick();
      rst = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'h1111_1113;
      tick();
      imem_rvalid = 1'b0;
      chk("t8_post_instr", instr, 32'h0000_0013);
      chk("t8_post_irv", ir_valid, 0);
      chk("t8_post_busy", fetch_busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
